// File: rtl/handshake_window_seq_if.sv
// Handshake bundle between a requesting master and handshake_window_seq.
//   start, c, b          : master -> sequencer (request, phase-1, phase-2)
//   ce, busy, done, err  : sequencer -> master (enable, busy, outcome pulses)
//   err_code             : classified failure reason, held until next start
//   ok_cnt, fail_cnt     : saturating outcome counters (CNT_W wide)
interface handshake_window_seq_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic             c;
  logic             b;
  logic             ce;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output start, c, b,
    input  ce, busy, done, err, err_code, ok_cnt, fail_cnt
  );

  modport slave (
    input  start, c, b,
    output ce, busy, done, err, err_code, ok_cnt, fail_cnt
  );
endinterface

// File: rtl/handshake_window_seq.sv
// Windowed handshake transaction sequencer.
// A start pulse in IDLE opens a transaction and raises ce. The unit must
// answer with c within 1..WIN_MAX cycles and with b exactly one cycle
// after c. Outcome is reported as a one-cycle done or err pulse plus a
// held err_code; saturating ok/fail counters track the history.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : handshake_window_seq_if.slave (start/c/b in; ce/busy/done/err/
//            err_code/ok_cnt/fail_cnt out, all registered)
// Optional build macro HWSEQ_SVA_EN compiles in protocol assertions.
module handshake_window_seq #(
  parameter int WIN_MAX = 5,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  handshake_window_seq_if.slave bus
);

  localparam int WW = $clog2(WIN_MAX + 1);
  localparam logic [WW-1:0]    WMAX    = WW'(WIN_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_C, WAIT_B} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    ok_d    = ok_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        // c and b are don't-care here; only start opens a transaction
        if (bus.start) begin
          state_d = WAIT_C;
          wcnt_d  = WW'(1);
          code_d  = 2'b00;
        end
      end
      WAIT_C: begin
        // b is deliberately ignored in this state, even alongside c
        if (bus.c) begin
          state_d = WAIT_B;
        end else if (wcnt_q == WMAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = 2'b01;
          fail_d  = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_W'(1);
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      WAIT_B: begin
        state_d = IDLE;
        if (bus.b) begin
          done_d = 1'b1;
          ok_d   = (ok_q == CNT_MAX) ? ok_q : ok_q + CNT_W'(1);
        end else begin
          err_d  = 1'b1;
          code_d = 2'b10;
          fail_d = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // busy/ce follow the next state so they are plain flops at the output
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      ok_q    <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.ce       = busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;
  assign bus.ok_cnt   = ok_q;
  assign bus.fail_cnt = fail_q;

`ifdef HWSEQ_SVA_EN
  // Length of the current busy run, saturating just past the legal bound.
  localparam int RW = $clog2(WIN_MAX + 3);
  logic [RW-1:0] run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         run_q <= '0;
    else if (!busy_q)                   run_q <= '0;
    else if (run_q != RW'(WIN_MAX + 2)) run_q <= run_q + RW'(1);
  end

  a_done_cause: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> ($past(bus.b) && $past(busy_q)))
    else $error("%0t: done without preceding b while busy", $time);

  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(done_q && err_q))
    else $error("%0t: done and err high together", $time);

  a_ce_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> bus.ce)
    else $error("%0t: ce low during transaction", $time);

  a_busy_bound: assert property (@(posedge clk) disable iff (!rst_n)
    run_q <= RW'(WIN_MAX + 1))
    else $error("%0t: transaction exceeded WIN_MAX+1 busy cycles", $time);
`else
  // No protocol checkers in this build.
`endif

endmodule

// File: tb/tb_handshake_window_seq.sv
// Directed bench for handshake_window_seq. Outcome pulses are checked by a
// scoreboard: the expected {done,err,code,ok,fail} is queued when the
// deciding input is driven and popped when the DUT pulses done/err.
module tb_handshake_window_seq;
  localparam int WIN_MAX = 5;
  localparam int CNT_W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  handshake_window_seq_if #(.CNT_W(CNT_W)) bus ();

  handshake_window_seq #(.WIN_MAX(WIN_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic       done;
    logic       err;
    logic [1:0] code;
    logic [7:0] ok;
    logic [7:0] fail;
  } exp_t;

  exp_t q[$];
  exp_t mon_obs, mon_exp;
  int   errors = 0;
  int   checks = 0;
  int   ok_m   = 0;
  int   fail_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1 || bus.err === 1'b1) begin
      mon_obs = '{bus.done, bus.err, bus.err_code, bus.ok_cnt, bus.fail_cnt};
      if (q.size() == 0) begin
        chk("sb_unexpected_pulse", 32'(mon_obs), 32'd0);
      end else begin
        mon_exp = q.pop_front();
        chk("sb_pulse", 32'(mon_obs), 32'(mon_exp));
      end
    end
  end

  task automatic expect_ok();
    if (ok_m < 255) ok_m++;
    q.push_back('{1'b1, 1'b0, 2'b00, 8'(ok_m), 8'(fail_m)});
  endtask

  task automatic expect_err(input logic [1:0] code);
    if (fail_m < 255) fail_m++;
    q.push_back('{1'b0, 1'b1, code, 8'(ok_m), 8'(fail_m)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(q.size()), 32'd0);
  endtask

  // Successful transaction with c on the k-th cycle after start.
  task automatic run_ok(input int k);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ce_after_start", 32'(bus.ce), 32'd1);
    for (int i = 1; i < k; i++) begin
      tick();
      chk("ce_wait_c", 32'(bus.ce), 32'd1);
    end
    bus.c = 1'b1;
    tick();
    chk("ce_wait_b", 32'(bus.ce), 32'd1);
    bus.c = 1'b0;
    bus.b = 1'b1;
    expect_ok();
    tick();
    bus.b = 1'b0;
    chk("ce_after_done", 32'(bus.ce), 32'd0);
    chk("code_ok", 32'(bus.err_code), 32'd0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.c     = 1'b0;
    bus.b     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset values
    chk("rst_ce",   32'(bus.ce),       32'd0);
    chk("rst_busy", 32'(bus.busy),     32'd0);
    chk("rst_done", 32'(bus.done),     32'd0);
    chk("rst_err",  32'(bus.err),      32'd0);
    chk("rst_code", 32'(bus.err_code), 32'd0);
    chk("rst_ok",   32'(bus.ok_cnt),   32'd0);
    chk("rst_fail", 32'(bus.fail_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic success, c two cycles after start; also c/b in IDLE ignored
    bus.c = 1'b1;
    bus.b = 1'b1;
    tick();
    chk("idle_ignores_cb", 32'(bus.busy), 32'd0);
    bus.c = 1'b0;
    bus.b = 1'b0;
    run_ok(2);
    chk("ok_cnt_1", 32'(bus.ok_cnt), 32'd1);

    // c on the last legal window cycle is still accepted
    run_ok(WIN_MAX);

    // c timeout
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < WIN_MAX; i++) begin
      tick();
      chk("ce_timeout_wait", 32'(bus.ce), 32'd1);
    end
    expect_err(2'b01);
    tick();
    chk("ce_timeout_low", 32'(bus.ce), 32'd0);
    chk("code_timeout",   32'(bus.err_code), 32'd1);
    drain();
    chk("fail_cnt_1", 32'(bus.fail_cnt), 32'd1);

    // b missing, then immediate restart clears err_code
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.c = 1'b1;
    tick();
    bus.c = 1'b0;
    expect_err(2'b10);
    tick();
    chk("code_b_missing", 32'(bus.err_code), 32'd2);
    drain();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_code_clr", 32'(bus.err_code), 32'd0);
    chk("restart_busy",     32'(bus.busy),     32'd1);
    bus.c = 1'b1;
    tick();
    bus.c = 1'b0;
    bus.b = 1'b1;
    expect_ok();
    tick();
    bus.b = 1'b0;
    drain();

    // b together with c is ignored; b absent next cycle -> error 10
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.c = 1'b1;
    bus.b = 1'b1;
    tick();
    bus.c = 1'b0;
    bus.b = 1'b0;
    expect_err(2'b10);
    tick();
    chk("code_b_with_c", 32'(bus.err_code), 32'd2);
    drain();
    chk("fail_cnt_3", 32'(bus.fail_cnt), 32'd3);

    // start while busy is dropped
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    bus.start = 1'b0;
    bus.c = 1'b1;
    tick();
    bus.c = 1'b0;
    bus.b = 1'b1;
    bus.start = 1'b1;
    expect_ok();
    tick();
    bus.b = 1'b0;
    bus.start = 1'b0;
    chk("busy_start_dropped", 32'(bus.busy), 32'd0);
    drain();
    tick();
    chk("busy_stays_idle", 32'(bus.busy), 32'd0);

    // back-to-back successes until the ok counter saturates
    for (int n = 0; n < 300; n++) run_ok(1);
    chk("ok_cnt_sat", 32'(bus.ok_cnt), 32'd255);
    chk("fail_cnt_keep", 32'(bus.fail_cnt), 32'd3);

    // asynchronous reset in the middle of WAIT_C
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ce",   32'(bus.ce),       32'd0);
    chk("mid_rst_busy", 32'(bus.busy),     32'd0);
    chk("mid_rst_done", 32'(bus.done),     32'd0);
    chk("mid_rst_err",  32'(bus.err),      32'd0);
    chk("mid_rst_code", 32'(bus.err_code), 32'd0);
    chk("mid_rst_ok",   32'(bus.ok_cnt),   32'd0);
    chk("mid_rst_fail", 32'(bus.fail_cnt), 32'd0);
    ok_m   = 0;
    fail_m = 0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_ok(2);
    chk("post_rst_ok", 32'(bus.ok_cnt), 32'd1);
    chk("post_rst_fail", 32'(bus.fail_cnt), 32'd0);

    repeat (2) tick();
    chk("sb_final_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
